// File: rtl/multicycle_sequencer_if.sv
// Shared RAM port between the sequencer (master) and the memory (slave).
// One request at a time; mem_req is held until mem_ready completes it.
interface multicycle_sequencer_if #(
  parameter int PC_W = 12
);
  logic            mem_req;
  logic            mem_we;
  logic [PC_W-1:0] mem_addr;
  logic [15:0]     mem_rdata;
  logic            mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the 16-bit CPU: owns PC/IR/flags, shares one RAM port
// between fetch and LD/ST. Define SEQ_WATCHDOG_EN to trap on overlong mem_ready waits.
module multicycle_sequencer #(
  parameter int PC_W        = 12,
  parameter int WDOG_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [15:0]             operand_1,
  input  logic [15:0]             operand_2,
  multicycle_sequencer_if.master  bus,
  output logic [15:0]             ir,
  output logic [PC_W-1:0]         pc,
  output logic                    reg_we,
  output logic                    mem_to_reg,
  output logic                    imm_sel,
  output logic                    alu_op,
  output logic                    zf,
  output logic                    cf,
  output logic                    busy,
  output logic                    trap
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [3:0] OP_AND  = 4'h1, OP_ADD  = 4'h2, OP_LD   = 4'h3, OP_ST   = 4'h4,
                         OP_ANDI = 4'h5, OP_ADDI = 4'h7, OP_CMP  = 4'h8, OP_JMP  = 4'h9,
                         OP_JE   = 4'hA, OP_JA   = 4'hB, OP_JB   = 4'hC, OP_JBE  = 4'hD,
                         OP_JAE  = 4'hE;

  state_t          state, state_n;
  logic [PC_W-1:0] pc_n;
  logic [15:0]     ir_n;
  logic            zf_n, cf_n;
  logic            req, we;
  logic [PC_W-1:0] addr;
  logic            wdog_hit;

  logic [3:0] op;
  logic       is_ld, is_st, illegal, taken;
  logic [PC_W-1:0] pc_inc, pc_jmp;

  assign op      = ir[15:12];
  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  assign illegal = (op == 4'h0) || (op == 4'h6) || (op == 4'hF);
  assign pc_inc  = pc + PC_W'(1);
  assign pc_jmp  = pc + PC_W'(ir[11:0]);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JE:   taken = zf & ~cf;
      OP_JA:   taken = ~zf & ~cf;
      OP_JB:   taken = ~zf & cf;
      OP_JBE:  taken = zf | cf;
      OP_JAE:  taken = ~cf;
      default: taken = 1'b0;
    endcase
  end

`ifdef SEQ_WATCHDOG_EN
  // Counter is at least 8 bits; a wider WDOG_CYCLES widens it.
  localparam int WD_W = ($clog2(WDOG_CYCLES + 1) > 8) ? $clog2(WDOG_CYCLES + 1) : 8;
  logic [WD_W-1:0] wd_cnt;

  // Only FETCH/MEM raise mem_req, and both are left on mem_ready, so clearing
  // whenever no wait is in progress means each entry starts from zero.
  always_ff @(posedge clk) begin
    if (reset)                        wd_cnt <= '0;
    else if (req && !bus.mem_ready)   wd_cnt <= wd_cnt + WD_W'(1);
    else                              wd_cnt <= '0;
  end

  assign wdog_hit = req && !bus.mem_ready && (wd_cnt == WD_W'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_n       = ir;
    zf_n       = zf;
    cf_n       = cf;
    req        = 1'b0;
    we         = 1'b0;
    addr       = pc;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;

    case (state)
      S_IDLE: if (run) state_n = S_FETCH;

      S_FETCH: begin
        req  = 1'b1;
        addr = pc;
        if (bus.mem_ready) begin
          ir_n    = bus.mem_rdata;
          state_n = S_DECODE;
        end else if (wdog_hit) begin
          state_n = S_TRAP;
        end
      end

      S_DECODE: state_n = illegal ? S_TRAP : S_EXEC;

      S_EXEC: begin
        state_n = run ? S_FETCH : S_IDLE;
        case (op)
          OP_AND, OP_ADD, OP_ANDI, OP_ADDI: state_n = S_WB;
          OP_LD, OP_ST:                     state_n = S_MEM;
          OP_CMP: begin
            zf_n = (operand_1 == operand_2);
            cf_n = (operand_1 <  operand_2);
            pc_n = pc_inc;
          end
          default: pc_n = taken ? pc_jmp : pc_inc;
        endcase
      end

      S_MEM: begin
        req  = 1'b1;
        we   = is_st;
        addr = PC_W'(ir[7:0]);
        if (bus.mem_ready) begin
          if (is_ld) begin
            state_n = S_WB;
          end else begin
            pc_n    = pc_inc;
            state_n = run ? S_FETCH : S_IDLE;
          end
        end else if (wdog_hit) begin
          state_n = S_TRAP;
        end
      end

      S_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = is_ld;
        pc_n       = pc_inc;
        state_n    = run ? S_FETCH : S_IDLE;
      end

      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      zf    <= 1'b0;
      cf    <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ir    <= ir_n;
      zf    <= zf_n;
      cf    <= cf_n;
    end
  end

  assign bus.mem_req  = req;
  assign bus.mem_we   = we;
  assign bus.mem_addr = addr;

  assign imm_sel = (op == OP_ANDI) || (op == OP_ADDI);
  assign alu_op  = ir[13];
  assign busy    = (state != S_IDLE) && (state != S_TRAP);
  assign trap    = (state == S_TRAP);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a small RAM model behind the interface,
// register-file operands driven directly, expectations hand-computed per scenario.
module tb_multicycle_sequencer;
  localparam int PC_W = 12;

  logic clk = 1'b0;
  logic reset, run, ready_en;
  logic [15:0] operand_1, operand_2;
  logic [15:0] ir;
  logic [PC_W-1:0] pc;
  logic reg_we, mem_to_reg, imm_sel, alu_op, zf, cf, busy, trap;
  logic [15:0] mem [0:(1<<PC_W)-1];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_sequencer_if #(.PC_W(PC_W)) bus ();

  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.mem_ready = ready_en;

  multicycle_sequencer #(.PC_W(PC_W), .WDOG_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .run(run),
    .operand_1(operand_1), .operand_2(operand_2), .bus(bus),
    .ir(ir), .pc(pc), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
    .imm_sel(imm_sel), .alu_op(alu_op), .zf(zf), .cf(cf),
    .busy(busy), .trap(trap)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; ready_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < (1<<PC_W); i++) mem[i] = 16'h0000;
    operand_1 = '0; operand_2 = '0;
    do_reset();
    n_checks++; if (pc !== 12'h000) begin n_fail++; $display("FAIL reset_pc: got %h want 000", pc); end
    n_checks++; if (ir !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h want 0000", ir); end
    n_checks++; if ({zf, cf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {zf, cf}); end
    n_checks++; if ({bus.mem_req, reg_we, busy, trap} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes: got %b want 0000", {bus.mem_req, reg_we, busy, trap}); end
  endtask

  task automatic test_add();
    do_reset();
    mem[0] = 16'h2123;
    run = 1'b1; tick();
    n_checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 12'h000}) begin n_fail++; $display("FAIL add_fetch: got req/we/addr %b/%b/%h want 1/0/000", bus.mem_req, bus.mem_we, bus.mem_addr); end
    run = 1'b0; tick();
    n_checks++; if (ir !== 16'h2123) begin n_fail++; $display("FAIL add_ir: got %h want 2123", ir); end
    tick(); tick();
    n_checks++; if ({reg_we, mem_to_reg, alu_op, imm_sel} !== 4'b1010) begin n_fail++; $display("FAIL add_wb: got we/m2r/op/imm %b want 1010", {reg_we, mem_to_reg, alu_op, imm_sel}); end
    tick();
    n_checks++; if (pc !== 12'h001) begin n_fail++; $display("FAIL add_pc: got %h want 001", pc); end
    n_checks++; if ({reg_we, busy} !== 2'b00) begin n_fail++; $display("FAIL add_end: got we/busy %b want 00", {reg_we, busy}); end
  endtask

  task automatic test_imm();
    do_reset();
    mem[0] = 16'h7125;
    mem[1] = 16'h1123;
    run = 1'b1; tick(); tick();
    n_checks++; if ({imm_sel, alu_op} !== 2'b11) begin n_fail++; $display("FAIL addi_ctrl: got imm/op %b want 11", {imm_sel, alu_op}); end
    repeat (3) tick();
    run = 1'b0; tick();
    n_checks++; if ({imm_sel, alu_op} !== 2'b00) begin n_fail++; $display("FAIL and_ctrl: got imm/op %b want 00", {imm_sel, alu_op}); end
    repeat (3) tick();
    n_checks++; if (pc !== 12'h002) begin n_fail++; $display("FAIL imm_pc: got %h want 002", pc); end
  endtask

  task automatic test_ld();
    do_reset();
    mem[0] = 16'h3245;
    mem[12'h045] = 16'hBEEF;
    run = 1'b1; tick();
    run = 1'b0; tick(); tick(); tick();
    n_checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 12'h045}) begin n_fail++; $display("FAIL ld_mem: got req/we/addr %b/%b/%h want 1/0/045", bus.mem_req, bus.mem_we, bus.mem_addr); end
    tick();
    n_checks++; if ({reg_we, mem_to_reg, bus.mem_req} !== 3'b110) begin n_fail++; $display("FAIL ld_wb: got we/m2r/req %b want 110", {reg_we, mem_to_reg, bus.mem_req}); end
    n_checks++; if (pc !== 12'h000) begin n_fail++; $display("FAIL ld_pc_wb: got %h want 000", pc); end
    tick();
    n_checks++; if (pc !== 12'h001) begin n_fail++; $display("FAIL ld_pc: got %h want 001", pc); end
  endtask

  task automatic test_cmp_jump(input logic [15:0] jinst, input logic [11:0] exp_pc, input string name);
    do_reset();
    mem[0] = 16'h2123;
    mem[1] = 16'h8012;
    mem[2] = jinst;
    operand_1 = 16'd5; operand_2 = 16'd7;
    run = 1'b1; tick();
    repeat (7) tick();
    run = 1'b0;
    n_checks++; if ({zf, cf} !== 2'b01) begin n_fail++; $display("FAIL %s_flags: got zf/cf %b want 01", name, {zf, cf}); end
    n_checks++; if (bus.mem_addr !== 12'h002) begin n_fail++; $display("FAIL %s_fetch: got %h want 002", name, bus.mem_addr); end
    repeat (3) tick();
    n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL %s_pc: got %h want %h", name, pc, exp_pc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle: got busy %b want 0", name, busy); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    mem[0] = 16'h9FFF;
    mem[12'hFFF] = 16'h8012;
    operand_1 = 16'd9; operand_2 = 16'd9;
    run = 1'b1; tick();
    repeat (3) tick();
    n_checks++; if (bus.mem_addr !== 12'hFFF) begin n_fail++; $display("FAIL wrap_jmp: got %h want fff", bus.mem_addr); end
    run = 1'b0;
    repeat (3) tick();
    n_checks++; if (pc !== 12'h000) begin n_fail++; $display("FAIL wrap_pc: got %h want 000", pc); end
    n_checks++; if ({zf, cf} !== 2'b10) begin n_fail++; $display("FAIL wrap_flags: got zf/cf %b want 10", {zf, cf}); end
  endtask

  task automatic test_st_wait();
    do_reset();
    mem[0] = 16'h4130;
    run = 1'b1; tick();
    run = 1'b0; tick(); tick();
    ready_en = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b11, 12'h030}) begin n_fail++; $display("FAIL st_hold%0d: got req/we/addr %b/%b/%h want 1/1/030", i, bus.mem_req, bus.mem_we, bus.mem_addr); end
      if (i == 3) begin
        n_checks++; if (pc !== 12'h000) begin n_fail++; $display("FAIL st_pc_wait: got %h want 000", pc); end
        ready_en = 1'b1;
      end
      tick();
    end
    n_checks++; if (pc !== 12'h001) begin n_fail++; $display("FAIL st_pc: got %h want 001", pc); end
    n_checks++; if ({bus.mem_req, busy} !== 2'b00) begin n_fail++; $display("FAIL st_end: got req/busy %b want 00", {bus.mem_req, busy}); end
  endtask

  task automatic test_trap();
    do_reset();
    mem[0] = 16'h2123;
    mem[1] = 16'h6000;
    run = 1'b1; tick();
    repeat (6) tick();
    n_checks++; if ({trap, busy, bus.mem_req, reg_we} !== 4'b1000) begin n_fail++; $display("FAIL trap_enter: got trap/busy/req/we %b want 1000", {trap, busy, bus.mem_req, reg_we}); end
    n_checks++; if (pc !== 12'h001) begin n_fail++; $display("FAIL trap_pc: got %h want 001", pc); end
    repeat (3) tick();
    n_checks++; if ({trap, bus.mem_req} !== 2'b10) begin n_fail++; $display("FAIL trap_sticky: got trap/req %b want 10", {trap, bus.mem_req}); end
    reset = 1'b1; run = 1'b0; tick(); reset = 1'b0;
    n_checks++; if ({trap, busy, pc} !== {2'b00, 12'h000}) begin n_fail++; $display("FAIL trap_reset: got trap/busy %b pc %h want 00 000", {trap, busy}, pc); end
  endtask

  task automatic test_fetch_stall();
    do_reset();
    mem[0] = 16'h2123;
    ready_en = 1'b0;
    run = 1'b1; tick();
    run = 1'b0;
    repeat (3) tick();
    n_checks++; if ({bus.mem_req, trap, bus.mem_addr} !== {2'b10, 12'h000}) begin n_fail++; $display("FAIL stall_hold: got req/trap %b addr %h want 10 000", {bus.mem_req, trap}, bus.mem_addr); end
    tick();
`ifdef SEQ_WATCHDOG_EN
    n_checks++; if ({trap, bus.mem_req, busy} !== 3'b100) begin n_fail++; $display("FAIL wdog_trap: got trap/req/busy %b want 100", {trap, bus.mem_req, busy}); end
`else
    n_checks++; if ({trap, bus.mem_req, busy} !== 3'b011) begin n_fail++; $display("FAIL stall_wait: got trap/req/busy %b want 011", {trap, bus.mem_req, busy}); end
`endif
    reset = 1'b1; tick(); reset = 1'b0; ready_en = 1'b1;
    n_checks++; if ({bus.mem_req, busy, trap} !== 3'b000) begin n_fail++; $display("FAIL stall_abort: got req/busy/trap %b want 000", {bus.mem_req, busy, trap}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_ld();
    test_cmp_jump(16'hC010, 12'h012, "jb");
    test_cmp_jump(16'hB010, 12'h003, "ja");
    test_pc_wrap();
    test_st_wait();
    test_trap();
    test_fetch_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion before 200000");
    $fatal(1);
  end
endmodule
